// File: rtl/sha256_ctrl.sv
// sha256_ctrl: packs a pre-padded 32-bit word stream into 512-bit blocks for sha256_core,
// sequences the core's enable/reset and returns the digest over a valid/ready output.
module sha256_ctrl #(
    parameter int DigestWidth = 256
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [31:0]            s_data_i,
    input  logic                   s_valid_i,
    input  logic                   s_last_i,
    output logic                   s_ready_o,
    input  logic                   abort_i,
    output logic [511:0]           block_o,
    output logic                   enable_hash_o,
    output logic                   rst_hash_o,
    input  logic                   hold_i,
    input  logic                   idle_i,
    input  logic [DigestWidth-1:0] digest_i,
    input  logic                   digest_valid_i,
    output logic [DigestWidth-1:0] digest_o,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic                   err_o
);

    typedef enum logic [2:0] {
        ST_RST,
        ST_WAIT,
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [511:0]           buf_q, buf_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   buf_full_q, buf_full_d;
    logic                   msg_closed_q, msg_closed_d;
    logic                   last_loaded_q, last_loaded_d;
    logic                   err_q, err_d;
    logic [DigestWidth-1:0] digest_q, digest_d;
    logic                   out_valid_q, out_valid_d;
    logic                   accept;
    logic                   consume;
    logic                   in_stream;

    always_comb begin
        in_stream = (state_q == ST_IDLE) || (state_q == ST_RUN);
        s_ready_o = ~buf_full_q & ~msg_closed_q & in_stream;
        accept    = s_valid_i & s_ready_o;
        case (state_q)
            ST_IDLE: enable_hash_o = buf_full_q & idle_i;
            ST_RUN:  enable_hash_o = ~hold_i | buf_full_q;
            default: enable_hash_o = 1'b0;
        endcase
        consume    = enable_hash_o & (idle_i | hold_i) & buf_full_q;
        rst_hash_o = (state_q == ST_RST) & ~rst_i;
    end

    always_comb begin
        state_d       = state_q;
        buf_d         = buf_q;
        cnt_d         = cnt_q;
        buf_full_d    = buf_full_q;
        msg_closed_d  = msg_closed_q;
        last_loaded_d = last_loaded_q;
        err_d         = err_q;
        digest_d      = digest_q;
        out_valid_d   = out_valid_q;

        // Word slot is 511-32*cnt; a short final block keeps the zeros left by the last clear.
        if (accept) begin
            buf_d[{~cnt_q, 5'h1f} -: 32] = s_data_i;
            cnt_d = cnt_q + 4'd1;
            if ((cnt_q == 4'd15) || s_last_i) begin
                buf_full_d = 1'b1;
            end
            if (s_last_i) begin
                msg_closed_d = 1'b1;
            end
            if ((state_q == ST_IDLE) && (cnt_q == 4'd0)) begin
                err_d = 1'b0;
            end
            if (s_last_i && (cnt_q != 4'd15)) begin
                err_d = 1'b1;
            end
        end

        if (consume) begin
            buf_d         = '0;
            cnt_d         = 4'd0;
            buf_full_d    = 1'b0;
            last_loaded_d = msg_closed_q;
        end

        case (state_q)
            ST_RST: begin
                buf_d         = '0;
                cnt_d         = 4'd0;
                buf_full_d    = 1'b0;
                msg_closed_d  = 1'b0;
                last_loaded_d = 1'b0;
                state_d       = ST_WAIT;
            end
            ST_WAIT: begin
                msg_closed_d  = 1'b0;
                last_loaded_d = 1'b0;
                cnt_d         = 4'd0;
                if (idle_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (consume) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (digest_valid_i) begin
                    digest_d    = digest_i;
                    out_valid_d = 1'b1;
                    if (!last_loaded_q) begin
                        err_d = 1'b1;
                    end
                    state_d = ST_DONE;
                end else if (hold_i && !buf_full_q && last_loaded_q) begin
                    // Core is asking for more data after the final block: it never saw the end marker.
                    err_d   = 1'b1;
                    state_d = ST_RST;
                end
            end
            ST_DONE: begin
                if (out_ready_i) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_RST;
                end
            end
            default: state_d = ST_RST;
        endcase

        if (abort_i && (state_q != ST_RST) && (state_q != ST_WAIT)) begin
            buf_d         = '0;
            cnt_d         = 4'd0;
            buf_full_d    = 1'b0;
            msg_closed_d  = 1'b0;
            last_loaded_d = 1'b0;
            out_valid_d   = 1'b0;
            state_d       = ST_RST;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_RST;
            buf_q         <= '0;
            cnt_q         <= 4'd0;
            buf_full_q    <= 1'b0;
            msg_closed_q  <= 1'b0;
            last_loaded_q <= 1'b0;
            err_q         <= 1'b0;
            digest_q      <= '0;
            out_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            buf_q         <= buf_d;
            cnt_q         <= cnt_d;
            buf_full_q    <= buf_full_d;
            msg_closed_q  <= msg_closed_d;
            last_loaded_q <= last_loaded_d;
            err_q         <= err_d;
            digest_q      <= digest_d;
            out_valid_q   <= out_valid_d;
        end
    end

    assign block_o     = buf_q;
    assign digest_o    = digest_q;
    assign out_valid_o = out_valid_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_sha256_ctrl.sv
// tb_sha256_ctrl: runs sha256_ctrl against a behavioural stand-in for sha256_core and checks
// digests against message-level SHA-256 reference values.
`timescale 1ns/1ps
module tb_sha256_ctrl;

    localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                   32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [255:0] ABC_DIGEST = {32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                                           32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
    localparam logic [255:0] TWO_DIGEST = {32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
                                           32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1};
    localparam logic [31:0] K_TAB [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [31:0]  s_data_i;
    logic         s_valid_i;
    logic         s_last_i;
    logic         s_ready_o;
    logic         abort_i;
    logic [511:0] block_o;
    logic         enable_hash_o;
    logic         rst_hash_o;
    logic         hold_i;
    logic         idle_i;
    logic [255:0] digest_i;
    logic         digest_valid_i;
    logic [255:0] digest_o;
    logic         out_valid_o;
    logic         out_ready_i;
    logic         err_o;

    sha256_ctrl #(.DigestWidth(256)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_last_i(s_last_i), .s_ready_o(s_ready_o),
        .abort_i(abort_i), .block_o(block_o), .enable_hash_o(enable_hash_o), .rst_hash_o(rst_hash_o),
        .hold_i(hold_i), .idle_i(idle_i), .digest_i(digest_i), .digest_valid_i(digest_valid_i),
        .digest_o(digest_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] h_in, input logic [511:0] blk);
        logic [31:0]  w [64];
        logic [31:0]  v [8];
        logic [31:0]  t1, t2, s0, s1;
        logic [255:0] res;
        for (int t = 0; t < 16; t++) w[t] = 32'(blk >> (32 * (15 - t)));
        for (int t = 16; t < 64; t++) begin
            s0   = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
            s1   = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = w[t-16] + s0 + w[t-7] + s1;
        end
        for (int i = 0; i < 8; i++) v[i] = 32'(h_in >> (32 * (7 - i)));
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6]))
                 + K_TAB[t] + w[t];
            t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
        end
        res = '0;
        for (int i = 0; i < 8; i++) res = {res[223:0], 32'(h_in >> (32 * (7 - i))) + v[i]};
        return res;
    endfunction

    function automatic logic has_marker(input logic [511:0] blk, input int nbytes);
        logic found;
        found = 1'b0;
        for (int i = 0; i < nbytes; i++)
            if (8'(blk >> (8 * (63 - i))) == 8'h80) found = 1'b1;
        return found;
    endfunction

    // Core stand-in: 64 busy cycles per block, HOLD between blocks, digest pulse after the
    // block that carries the length field once the 0x80 marker has been seen.
    typedef enum int {CORE_IDLE, CORE_RUN, CORE_HOLD, CORE_DONE} core_state_e;
    core_state_e  core_state = CORE_IDLE;
    int           core_round = 0;
    logic [255:0] core_h = IV;
    logic         core_marker = 1'b0;
    logic         core_final = 1'b0;
    logic [511:0] core_blk = '0;
    logic         core_dv = 1'b0;

    assign idle_i         = (core_state == CORE_IDLE);
    assign hold_i         = (core_state == CORE_HOLD);
    assign digest_i       = core_h;
    assign digest_valid_i = core_dv;

    always @(posedge clk_i) begin
        core_dv <= 1'b0;
        if (rst_i || rst_hash_o) begin
            core_state  <= CORE_IDLE;
            core_h      <= IV;
            core_marker <= 1'b0;
            core_round  <= 0;
        end else begin
            case (core_state)
                CORE_IDLE, CORE_HOLD: begin
                    if (enable_hash_o) begin
                        core_blk    <= block_o;
                        core_h      <= sha_compress(core_h, block_o);
                        core_final  <= (block_o[63:0] != 64'd0) && (core_marker || has_marker(block_o, 56));
                        core_marker <= core_marker || has_marker(block_o, 64);
                        core_round  <= 0;
                        core_state  <= CORE_RUN;
                    end
                end
                CORE_RUN: begin
                    if (core_round == 63) begin
                        if (core_final) begin
                            core_dv    <= 1'b1;
                            core_state <= CORE_DONE;
                        end else begin
                            core_state <= CORE_HOLD;
                        end
                    end else begin
                        core_round <= core_round + 1;
                    end
                end
                default: ;
            endcase
        end
    end

    int   hold_cycles = 0;
    int   valid_rises = 0;
    logic valid_prev = 1'b0;
    always @(negedge clk_i) begin
        if (hold_i) hold_cycles <= hold_cycles + 1;
        if (out_valid_o && !valid_prev) valid_rises <= valid_rises + 1;
        valid_prev <= out_valid_o;
    end

    int vectors = 0;
    int miscompares = 0;
    byte unsigned msg[$];
    logic [31:0]  tx_words[$];

    task automatic check_output(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Pads msg, fills tx_words and returns the reference digest.
    function automatic logic [255:0] prepare_message();
        byte unsigned    p[$];
        logic [511:0]    blk;
        logic [255:0]    h;
        longint unsigned bit_len;
        p = msg;
        bit_len = 64'(msg.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(8'(bit_len >> (8 * i)));
        tx_words.delete();
        for (int i = 0; i < p.size(); i += 4) tx_words.push_back({p[i], p[i+1], p[i+2], p[i+3]});
        h = IV;
        for (int b = 0; b < p.size() / 64; b++) begin
            blk = '0;
            for (int i = 0; i < 64; i++) blk = {blk[503:0], p[64*b+i]};
            h = sha_compress(h, blk);
        end
        return h;
    endfunction

    function automatic void load_string(input string s);
        msg.delete();
        for (int i = 0; i < s.len(); i++) msg.push_back(8'(s[i]));
    endfunction

    function automatic void load_random(input int len);
        msg.delete();
        for (int i = 0; i < len; i++) msg.push_back(8'($urandom_range(32, 126)));
    endfunction

    task automatic apply_stimulus(input int stall_at, input int stall_cycles, input int gap_max);
        int n;
        @(posedge clk_i); #1;
        for (int i = 0; i < tx_words.size(); i++) begin
            if (i == stall_at) begin
                s_valid_i = 1'b0;
                n = 0;
                while (!hold_i && n < 200) begin @(negedge clk_i); n++; end
                check_output("stall_core_hold", 256'(hold_i), 256'(1));
                for (int c = 0; c < stall_cycles; c++) begin
                    @(negedge clk_i);
                    check_output("stall_enable_low", 256'(enable_hash_o), 256'(0));
                end
                @(posedge clk_i); #1;
            end
            repeat ($urandom_range(0, gap_max)) begin
                s_valid_i = 1'b0;
                @(posedge clk_i); #1;
            end
            s_data_i  = tx_words[i];
            s_valid_i = 1'b1;
            s_last_i  = (i == tx_words.size() - 1);
            n = 0;
            do begin @(negedge clk_i); n++; end while (!s_ready_o && n < 300);
            if (!s_ready_o) check_output("word_accept_timeout", 256'(s_ready_o), 256'(1));
            @(posedge clk_i); #1;
        end
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!s_ready_o && n < 200) begin @(negedge clk_i); n++; end
        check_output({tag, "_ready"}, 256'(s_ready_o), 256'(1));
    endtask

    task automatic wait_digest(input string tag, input logic [255:0] exp, input int ready_delay);
        int n = 0;
        while (!out_valid_o && n < 400) begin @(negedge clk_i); n++; end
        check_output({tag, "_valid"}, 256'(out_valid_o), 256'(1));
        check_output({tag, "_digest"}, digest_o, exp);
        for (int d = 0; d < ready_delay; d++) begin
            @(negedge clk_i);
            check_output({tag, "_stable"}, digest_o, exp);
            check_output({tag, "_sready_low"}, 256'(s_ready_o), 256'(0));
        end
        @(posedge clk_i); #1 out_ready_i = 1'b1;
        @(posedge clk_i); #1 out_ready_i = 1'b0;
        @(negedge clk_i);
        check_output({tag, "_valid_drop"}, 256'(out_valid_o), 256'(0));
        check_output({tag, "_rst_pulse"}, 256'(rst_hash_o), 256'(1));
        @(negedge clk_i);
        check_output({tag, "_rst_end"}, 256'(rst_hash_o), 256'(0));
        wait_ready(tag);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [255:0] exp;
        logic [511:0] exp_blk;
        int           base, n;

        rst_i = 1'b1; s_data_i = '0; s_valid_i = 1'b0; s_last_i = 1'b0;
        abort_i = 1'b0; out_ready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_output("reset_s_ready", 256'(s_ready_o), 256'(0));
        check_output("reset_rst_hash", 256'(rst_hash_o), 256'(0));
        check_output("reset_enable", 256'(enable_hash_o), 256'(0));
        check_output("reset_out_valid", 256'(out_valid_o), 256'(0));
        check_output("reset_err", 256'(err_o), 256'(0));
        check_output("reset_digest", digest_o, 256'(0));
        check_output("reset_block", 256'(block_o), 256'(0));
        @(posedge clk_i); #1 rst_i = 1'b0;
        @(negedge clk_i);
        check_output("startup_rst_pulse", 256'(rst_hash_o), 256'(1));
        @(negedge clk_i);
        check_output("startup_rst_end", 256'(rst_hash_o), 256'(0));
        wait_ready("startup");

        $display("[TB] case 1: abc");
        load_string("abc");
        void'(prepare_message());
        base = valid_rises;
        apply_stimulus(-1, 0, 0);
        wait_digest("abc", ABC_DIGEST, 0);
        repeat (5) @(negedge clk_i);
        check_output("abc_one_valid", 256'(valid_rises - base), 256'(1));
        check_output("abc_err", 256'(err_o), 256'(0));

        $display("[TB] case 2: two-block message");
        load_string("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
        void'(prepare_message());
        base = hold_cycles;
        apply_stimulus(-1, 0, 0);
        wait_digest("two", TWO_DIGEST, 0);
        check_output("two_hold_cycles", 256'(hold_cycles - base), 256'(1));

        $display("[TB] case 3: stall before block 2");
        apply_stimulus(16, 40, 0);
        wait_digest("stall", TWO_DIGEST, 0);
        check_output("stall_err", 256'(err_o), 256'(0));

        $display("[TB] case 4: output back-pressure");
        load_string("abc");
        void'(prepare_message());
        apply_stimulus(-1, 0, 0);
        wait_digest("bp", ABC_DIGEST, 20);

        $display("[TB] case 5: abort mid-block");
        base = valid_rises;
        apply_stimulus(-1, 0, 0);
        n = 0;
        while (!(core_state == CORE_RUN && core_round == 30) && n < 300) begin @(negedge clk_i); n++; end
        abort_i = 1'b1;
        @(posedge clk_i); #1 abort_i = 1'b0;
        @(negedge clk_i);
        check_output("abort_rst_pulse", 256'(rst_hash_o), 256'(1));
        check_output("abort_out_valid", 256'(out_valid_o), 256'(0));
        @(negedge clk_i);
        check_output("abort_core_idle", 256'(idle_i), 256'(1));
        wait_ready("abort");
        check_output("abort_no_valid", 256'(valid_rises - base), 256'(0));
        apply_stimulus(-1, 0, 0);
        wait_digest("after_abort", ABC_DIGEST, 0);
        check_output("after_abort_err", 256'(err_o), 256'(0));

        $display("[TB] case 6: early last without marker");
        tx_words.delete();
        exp_blk = '0;
        for (int i = 0; i < 5; i++)
            tx_words.push_back({8'($urandom_range(32, 126)), 8'($urandom_range(32, 126)),
                                8'($urandom_range(32, 126)), 8'($urandom_range(32, 126))});
        for (int i = 0; i < 16; i++) exp_blk = {exp_blk[479:0], (i < 5) ? tx_words[i] : 32'd0};
        base = valid_rises;
        apply_stimulus(-1, 0, 0);
        @(negedge clk_i);
        check_output("early_last_err", 256'(err_o), 256'(1));
        n = 0;
        while (!rst_hash_o && n < 200) begin @(negedge clk_i); n++; end
        check_output("early_last_rst_pulse", 256'(rst_hash_o), 256'(1));
        check_output("early_last_block_lo", 256'(core_blk), exp_blk[255:0]);
        check_output("early_last_block_hi", 256'(core_blk >> 256), exp_blk[511:256]);
        wait_ready("early_last");
        check_output("early_last_err_sticky", 256'(err_o), 256'(1));
        check_output("early_last_no_valid", 256'(valid_rises - base), 256'(0));
        load_random(20);
        exp = prepare_message();
        apply_stimulus(-1, 0, 0);
        wait_digest("recover", exp, 0);
        check_output("recover_err", 256'(err_o), 256'(0));

        $display("[TB] random messages");
        for (int m = 0; m < 5; m++) begin
            load_random($urandom_range(1, 150));
            exp = prepare_message();
            apply_stimulus(-1, 0, 2);
            wait_digest("random", exp, $urandom_range(0, 4));
            check_output("random_err", 256'(err_o), 256'(0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
